// File: rtl/uart_rx_pkg.sv
// Shared widths and depths for the UART receive path.
// FSM, deserializer and RX FIFO all take their defaults from here.
package uart_rx_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 8;
    localparam int DROP_CNT_W         = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/rise_detect.sv
// Level-to-pulse converter.
// Fires once on the first cycle a level is seen high.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic dv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= level;
        end
    end

    assign pulse = level & ~dv_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte buffer behind the UART receive FSM.
// One push per data_valid rise, registered pop, sticky overflow tracking.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  wr;
    logic                  drop;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (data_valid),
        .pulse (push)
    );

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign pop   = rd_en & ~empty;
    // A pop in the same cycle frees the slot the push needs
    assign wr    = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= pop;
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            if (wr && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_CNT_W'(1);
            end else if (drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Stimulus queues expected bytes; a monitor checks every rd_valid pulse.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       data_valid;
    logic [7:0] P_DATA;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .P_DATA     (P_DATA),
        .rd_en      (rd_en),
        .ovf_clr    (ovf_clr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_data=%02h, required no pop", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %02h, required %02h", rd_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input int hold, input bit store);
        P_DATA     = b;
        data_valid = 1'b1;
        if (store) exp_q.push_back(b);
        repeat (hold) tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        data_valid = 1'b0;
        P_DATA     = 8'h00;
        rd_en      = 1'b0;
        ovf_clr    = 1'b0;
        #12;
        check("reset_empty", empty, 1);
        check("reset_count", count, 0);
        check("reset_full", full, 0);
        check("reset_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Long data_valid yields a single push
        P_DATA     = 8'hA5;
        data_valid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        check("long_dv_count_first", count, 1);
        repeat (5) tick();
        check("long_dv_count_held", count, 1);
        data_valid = 1'b0;
        tick();
        drain(1);
        check("pop_a5_empty", empty, 1);

        // Overflow on ninth frame
        for (int i = 0; i < 8; i++) frame(8'(i), 1, 1'b1);
        frame(8'hFF, 1, 1'b0);
        check("ovf_full", full, 1);
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_cnt", drop_cnt, 1);
        drain(8);
        check("ovf_drained_empty", empty, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_flag", overflow, 0);
        check("ovf_clr_cnt", drop_cnt, 0);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1, 1'b1);
        P_DATA     = 8'hAA;
        data_valid = 1'b1;
        rd_en      = 1'b1;
        exp_q.push_back(8'hAA);
        tick();
        data_valid = 1'b0;
        rd_en      = 1'b0;
        check("full_pushpop_count", count, 8);
        check("full_pushpop_ovf", overflow, 0);
        tick();
        drain(8);
        check("full_pushpop_empty", empty, 1);

        // Push and pop together while empty
        P_DATA     = 8'h5C;
        data_valid = 1'b1;
        rd_en      = 1'b1;
        tick();
        check("empty_pushpop_rd_valid", rd_valid, 0);
        check("empty_pushpop_count", count, 1);
        data_valid = 1'b0;
        rd_en      = 1'b0;
        exp_q.push_back(8'h5C);
        tick();
        drain(1);
        check("empty_pushpop_drained", empty, 1);

        // Saturating drop counter
        for (int i = 0; i < 8; i++) frame(8'h20 + 8'(i), 1, 1'b1);
        for (int i = 0; i < 300; i++) frame(8'hEE, 1, 1'b0);
        check("sat_drop_cnt", drop_cnt, 255);
        check("sat_overflow", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sat_clr_cnt", drop_cnt, 0);
        check("sat_clr_flag", overflow, 0);
        P_DATA     = 8'hEE;
        data_valid = 1'b1;
        ovf_clr    = 1'b1;
        tick();
        data_valid = 1'b0;
        ovf_clr    = 1'b0;
        check("clr_vs_drop_cnt", drop_cnt, 1);
        check("clr_vs_drop_flag", overflow, 1);
        tick();
        drain(8);
        check("sat_drained_empty", empty, 1);

        // Asynchronous reset with entries stored and rd_en high
        for (int i = 0; i < 5; i++) frame(8'h30 + 8'(i), 1, 1'b1);
        check("pre_rst_count", count, 5);
        rd_en = 1'b1;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_empty", empty, 1);
        frame(8'h77, 1, 1'b1);
        rd_en = 1'b0;
        tick();
        check("post_rst_final_empty", empty, 1);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART RX control FSM and deserializer. It captures one `P_DATA` byte per accepted frame, on the rising edge of the FSM's level-type `data_valid`. Bytes are held in a small synchronous FIFO until the host pops them. Overflow is reported through a sticky flag and a saturating drop counter.

## Interface
Parameters:
- `DATA_WIDTH`, 8: frame payload width; must match the deserializer output.
- `DEPTH`, 8: number of FIFO entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

Ports:
- `clk`  in  1  — the single clock. Same domain as the RX FSM.
- `rst_n`  in  1  — reset. Asynchronous, active-low.
- `data_valid`  in  1  — from the RX FSM. A level that may stay high for several cycles per frame.
- `P_DATA`  in  DATA_WIDTH  — parallel byte from the deserializer. Stable while `data_valid` is high.
- `rd_en`  in  1  — pop request from the consumer.
- `ovf_clr`  in  1  — clears `overflow` and `drop_cnt`.
- `rd_data`  out  DATA_WIDTH  — popped byte. Registered.
- `rd_valid`  out  1  — one-cycle pulse; `rd_data` is valid in that cycle.
- `empty`  out  1  — no entries stored.
- `full`  out  1  — `count == DEPTH`.
- `count`  out  CNT_W  — number of stored entries.
- `overflow`  out  1  — sticky. Set when a frame is dropped because the FIFO is full.
- `drop_cnt`  out  8  — number of dropped frames. Saturates at 255.

## Operation
- Push detect:
  - Register `dv_q <= data_valid`.
  - `push = data_valid & ~dv_q`, so exactly one push per frame however long `data_valid` stays high.
  - Back-to-back frames with `data_valid` low for ≥1 cycle between them produce two pushes.
- Pop:
  - `pop = rd_en & ~empty`.
  - `rd_en` while empty is ignored: no pointer change, `rd_valid` stays 0.
- Storage:
  - Register array `mem[DEPTH]`.
  - `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
  - `count` is held as a separate register; `empty` and `full` are decoded from `count`.
- Push while full, no pop in the same cycle:
  - The byte is discarded; `mem`, `wr_ptr` and `count` are unchanged.
  - `overflow` is set to 1.
  - `drop_cnt` increments unless it is already 255.
- Push and pop in the same cycle:
  - When full: both take effect, `count` unchanged, no overflow.
  - When empty: the push only takes effect, since `pop` = 0 (no bypass path). `rd_valid` = 0 that cycle.
  - Otherwise: both take effect, `count` unchanged.
- `ovf_clr`:
  - Clears `overflow` and `drop_cnt` at the next edge.
  - If a drop happens in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Reset (asynchronous, at any time including mid-frame or mid-pop):
  - `wr_ptr`, `rd_ptr`, `count`, `dv_q`, `overflow`, `drop_cnt`, `rd_valid` = 0.
  - `rd_data` = 0.
  - `empty` = 1, `full` = 0.
  - `mem` contents are not reset.
  - Because `dv_q` resets to 0, a `data_valid` that is already high when `rst_n` releases counts as a push on the first clock edge.

## Timing
- Push latency: the byte is written at the clock edge ending the first cycle in which `data_valid` is high. `count` and `empty` update at that same edge.
- Pop latency: 1 cycle. With `rd_en` high in cycle N and the FIFO non-empty, `rd_valid` = 1 and `rd_data = mem[rd_ptr]` in cycle N+1.
- `rd_valid` is high for exactly one cycle per pop. Continuous `rd_en` gives one byte per cycle until the FIFO is empty.
- `empty`, `full`, `count`, `overflow` and `drop_cnt` are all registered, with no combinational path from inputs.
- `rd_data` holds its last value when `rd_valid` = 0.

## Structure
- `uart_rx_pkg` holds:
  - `UART_DATA_W` = 8.
  - `UART_RX_FIFO_DEPTH` = 8.
  - `DROP_CNT_W` = 8 and `DROP_CNT_MAX` = 8'hFF.
  - Defaults for the parameters above, so the FSM, deserializer and FIFO widths agree.
- One sub-module, `rise_detect`: the `dv_q` flop plus the AND gate, reusable for other level-to-pulse needs in the RX path.
- Everything else (pointers, count, memory, overflow logic) stays in `uart_rx_fifo`.

## Test plan
- Reset, then hold `data_valid` high for 6 cycles with `P_DATA` = 8'hA5, then `rd_en` for 1 cycle:
  - `count` goes 0→1 only once.
  - `rd_valid` pulses the next cycle with `rd_data` = 8'hA5, then `empty` = 1.
- Push 8 frames 8'h00..8'h07, then a 9th frame 8'hFF:
  - `full` = 1, `overflow` = 1, `drop_cnt` = 1.
  - Popping 8 times returns 00..07 in order; 8'hFF never appears.
- With the FIFO full, push and `rd_en` in the same cycle:
  - `count` stays 8 and `overflow` stays 0.
  - The new byte is returned last after draining.
- With the FIFO empty, push and `rd_en` in the same cycle:
  - `rd_valid` = 0, `count` = 1.
  - The next `rd_en` returns the byte.
- Cause 300 drops, then assert `ovf_clr`:
  - `drop_cnt` holds at 255, then reads 0; `overflow` reads 0.
  - Repeat with `ovf_clr` coincident with a drop: `drop_cnt` = 1, `overflow` = 1.
- Assert `rst_n` low with 5 entries stored and `rd_en` high:
  - All outputs return to reset values immediately.
  - After release, `rd_en` produces no `rd_valid` until a new frame arrives.
